// File: rtl/button_conditioner.sv
// Pushbutton front end: per-button 2-flop synchroniser, debounce counter,
// registered press/release edge pulses and a press/auto-repeat pulse stream.
module button_conditioner #(
    parameter int NUM_BTN              = 5,
    parameter int DEBOUNCE_CYCLES      = 2_000_000,
    parameter int REPEAT_DELAY_CYCLES  = 50_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RDLY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RPER_LAST  = RW'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic          sync1_q, sync2_q;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic          level_q, level_d;
        logic          press_q, release_q, repeat_q, repeat_d;
        logic          rise, fall;
        rpt_state_t    state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;

        // Any sample that matches the current level restarts the stability count.
        always_comb begin
            dcnt_d  = '0;
            level_d = level_q;
            if (sync2_q != level_q) begin
                if (dcnt_q == DCNT_LAST) begin
                    level_d = sync2_q;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
        end

        assign rise = level_d & ~level_q;
        assign fall = ~level_d & level_q;

        // A debounced fall overrides everything, including a coincident terminal count.
        always_comb begin
            state_d  = state_q;
            rcnt_d   = rcnt_q;
            repeat_d = 1'b0;
            if (fall) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            repeat_d = 1'b1;
                            rcnt_d   = '0;
                            state_d  = ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (rcnt_q == RDLY_LAST) begin
                            repeat_d = 1'b1;
                            rcnt_d   = '0;
                            state_d  = ST_REPEAT;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt_q == RPER_LAST) begin
                            repeat_d = 1'b1;
                            rcnt_d   = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                dcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
                state_q   <= ST_IDLE;
                rcnt_q    <= '0;
            end else begin
                sync1_q   <= btn_raw[gi];
                sync2_q   <= sync1_q;
                dcnt_q    <= dcnt_d;
                level_q   <= level_d;
                press_q   <= rise;
                release_q <= fall;
                repeat_q  <= repeat_d;
                state_q   <= state_d;
                rcnt_q    <= rcnt_d;
            end
        end

        assign btn_level[gi]   = level_q;
        assign btn_press[gi]   = press_q;
        assign btn_release[gi] = release_q;
        assign btn_repeat[gi]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

    localparam int NB  = 5;
    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
    localparam int NO_FALL = 100000;

    logic          clk;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

    int checks;
    int failures;
    logic [19:0] exp_q[$];

    button_conditioner #(
        .NUM_BTN(NB),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_PERIOD_CYCLES(PER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_repeat(btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {level, press, release, repeat} of one button whose debounced
    // level rises at cycle r and falls at cycle f.
    function automatic logic [3:0] hold_vec(int k, int r, int f);
        logic lvl, prs, rel, rep;
        lvl = (k >= r) && (k < f);
        prs = (k == r);
        rel = (k == f);
        rep = lvl && ((k == r) || (k == r + DLY) ||
                      ((k > r + DLY) && (((k - r - DLY) % PER) == 0)));
        return {lvl, prs, rel, rep};
    endfunction

    function automatic logic [19:0] place(int b, logic [3:0] v);
        logic [19:0] o;
        o = '0;
        o[15 + b] = v[3];
        o[10 + b] = v[2];
        o[5 + b]  = v[1];
        o[b]      = v[0];
        return o;
    endfunction

    task automatic test_reset();
        logic [19:0] exp, got;
        for (int k = 1; k <= 23; k++) exp_q.push_back(20'h0);
        reset   = 1'b1;
        btn_raw = '0;
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 3) reset = 1'b0;
        end
    endtask

    task automatic test_press_repeat();
        logic [19:0] exp, got;
        for (int k = 1; k <= 40; k++) exp_q.push_back(place(1, hold_vec(k, 6, 30)));
        btn_raw = 5'b00010;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL press_repeat k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 24) btn_raw = '0;
        end
    endtask

    task automatic test_glitch();
        logic [19:0] exp, got;
        // 3-cycle pulse is rejected; 4-cycle pulse starting at k=16 is accepted.
        for (int k = 1; k <= 15; k++) exp_q.push_back(20'h0);
        for (int k = 16; k <= 35; k++) exp_q.push_back(place(2, hold_vec(k - 15, 6, 10)));
        btn_raw = 5'b00100;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL glitch k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 3 || k == 19) btn_raw = '0;
            if (k == 15) btn_raw = 5'b00100;
        end
    endtask

    task automatic test_bounce_release();
        logic [19:0] exp, got;
        for (int k = 1; k <= 50; k++) exp_q.push_back(place(4, hold_vec(k, 6, 40)));
        btn_raw = 5'b10000;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL bounce_release k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 30 || k == 32 || k == 34) btn_raw = '0;
            if (k == 31 || k == 33) btn_raw = 5'b10000;
        end
    endtask

    task automatic test_simultaneous();
        logic [19:0] exp, got;
        for (int k = 1; k <= 25; k++)
            exp_q.push_back(place(0, hold_vec(k, 6, 18)) | place(4, hold_vec(k, 6, 18)));
        btn_raw = 5'b10001;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL simultaneous k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 12) btn_raw = '0;
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp, got;
        for (int k = 1; k <= 55; k++) begin
            if (k <= 20)      exp_q.push_back(place(3, hold_vec(k, 6, NO_FALL)));
            else if (k <= 22) exp_q.push_back(20'h0);
            else              exp_q.push_back(place(3, hold_vec(k, 28, 51)));
        end
        btn_raw = 5'b01000;
        for (int k = 1; k <= 55; k++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            got = {btn_level, btn_press, btn_release, btn_repeat};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_mid k=%0d got=%h exp=%h", k, got, exp);
            end
            if (k == 20) reset = 1'b1;
            if (k == 22) reset = 1'b0;
            if (k == 45) btn_raw = '0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        btn_raw  = '0;
        test_reset();
        test_press_repeat();
        test_glitch();
        test_bounce_release();
        test_simultaneous();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
